instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the datapath; owns the fetch PC.
- Issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PCs in a small FIFO and presents them on a valid/ready interface to the datapath's `instruction` input.
- Handles redirects (branch/jump/trap) by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2; also the cap on outstanding + buffered words.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word-aligned fetch address; equals fetch_pc.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata  input  32  response word.
- redirect_valid  input  1  load a new fetch PC.
- redirect_pc  input  32  new PC; bits [1:0] are forced to 0.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  datapath consumes the head.
- instruction  output  32  head instruction word.
- instr_pc  output  32  PC of the head instruction.

Behaviour:
- **Reset (async):**
  - fetch_pc = resp_pc = RESET_PC.
  - FIFO empty, outstanding = 0, discard = 0, state = BOOT.
  - imem_req = 0, instr_valid = 0, instruction = 0, instr_pc = 0.
  - Reset asserted mid-operation abandons all in-flight requests immediately.
- **FSM states:** BOOT, FETCH, FLUSH.
  - BOOT: lasts exactly 1 cycle after reset deasserts, with imem_req = 0, then goes to FETCH.
  - FETCH: imem_req = 1 iff outstanding + fifo_count < FIFO_DEPTH.
  - FLUSH: imem_req = 0.
- **Grant:** on imem_req & imem_gnt, fetch_pc += 4 (32-bit wrap) and outstanding += 1.
- **Response in FETCH** (imem_rvalid): push {imem_rdata, resp_pc}, resp_pc += 4, outstanding -= 1.
  - A push to a full FIFO cannot occur because of the credit rule.
  - A simultaneous push and pop is legal at any occupancy.
- **Pop:** instr_valid & instr_ready removes the head.
  - instr_valid = FIFO non-empty; instruction and instr_pc are driven from the head entry.
- **Latency:** gnt in cycle N, rvalid in cycle N+1 → instr_valid in cycle N+2.
- **Redirect** (any state except reset):
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; a same-cycle pop and push are ignored.
  - discard = outstanding after this cycle's gnt/rvalid accounting; a request granted in the redirect cycle is counted and discarded.
  - Next state = FLUSH if discard > 0, else FETCH.
- **Redirect in BOOT:** PC is updated; BOOT still exits to FETCH.
- **FLUSH:**
  - Each rvalid is dropped; discard -= 1 and outstanding -= 1.
  - When discard reaches 0, the next state is FETCH and a request may be issued in that next cycle.
  - A redirect during FLUSH updates the PCs only; discard is unchanged.
- **No-req checks:** imem_rvalid with outstanding == 0 is a protocol error (assertion only; no recovery logic).

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds output port `perf_fetched` (32) counting FIFO pushes.
  - Adds output port `perf_discarded` (32) counting dropped responses.
  - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- **Reset/boot:** reset high 2 cycles, release → imem_req = 0 for 1 cycle, then imem_req = 1 with imem_addr = 0x0.
- **Streaming:** memory gnt every cycle, rvalid 1 cycle later with rdata = addr ^ 0xA5A5_0000, instr_ready = 1 → instr_pc sequence 0x0, 0x4, 0x8, 0xC; instruction matches; first instr_valid 2 cycles after first gnt.
- **Backpressure:** instr_ready = 0 → exactly FIFO_DEPTH (2) grants, then imem_req = 0; release ready → fetch resumes at 0x8 with no loss or duplication.
- **Redirect with 2 in flight:** redirect_pc = 0x103 → next imem_addr not issued until 2 responses are dropped; then imem_addr = 0x100 and first instr_pc = 0x100.
- **Redirect + gnt same cycle:** that granted response is discarded; no instr_pc equal to the old address appears after redirect.
- **Async reset mid-FLUSH:** outputs drop to 0 without a clock edge; after release, fetch restarts at RESET_PC; with IFETCH_PERF_EN, perf_discarded counts only pre-reset drops and then reads 0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_fetch: fetch PC owner, imem req/gnt/rvalid master, instr FIFO.     |
// | Optional macro IFETCH_PERF_EN adds perf_fetched/perf_discarded counters. |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     word_q [FIFO_DEPTH];
  logic [31:0]     word_d [FIFO_DEPTH];
  logic [31:0]     pcmem_q [FIFO_DEPTH];
  logic [31:0]     pcmem_d [FIFO_DEPTH];

  logic        gnt, rsp, push, pop, drop;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? word_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? pcmem_q[rd_ptr_q] : 32'h0;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    word_d        = word_q;
    pcmem_d       = pcmem_q;
    imem_req      = 1'b0;

    case (state_q)
      BOOT:    state_d  = FETCH;
      // Credit rule: in-flight plus buffered words never exceed the FIFO size.
      FETCH:   imem_req = ({1'b0, outstanding_q} + {1'b0, count_q}) < C_DEPTH;
      FLUSH:   imem_req = 1'b0;
      default: state_d  = BOOT;
    endcase

    gnt  = imem_req & imem_gnt;
    rsp  = imem_rvalid & (outstanding_q != '0);
    pop  = instr_valid & instr_ready & ~redirect_valid;
    push = rsp & (state_q == FETCH) & ~redirect_valid;
    drop = rsp & ~push;

    outstanding_d = outstanding_q + CW'(gnt) - CW'(rsp);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (gnt) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push) begin
      word_d[wr_ptr_q]  = imem_rdata;
      pcmem_d[wr_ptr_q] = resp_pc_q;
      wr_ptr_d          = wr_ptr_q + PW'(1);
      resp_pc_d         = resp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if ((state_q == FLUSH) && rsp) begin
      discard_d = discard_q - CW'(1);
      if (discard_d == '0) state_d = FETCH;
    end

    // In FLUSH every in-flight word is already being discarded, so only the PCs move.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (state_q == FETCH) begin
        discard_d = outstanding_d;
        state_d   = (outstanding_d != '0) ? FLUSH : FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_q[i]  <= 32'h0;
        pcmem_q[i] <= 32'h0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      word_q        <= word_d;
      pcmem_q       <= pcmem_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + 32'(push);
    perf_discarded_d = perf_discarded_q + 32'(drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q   <= 32'h0;
      perf_discarded_q <= 32'h0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding_q != '0));

endmodule
`default_nettype wire
